// File: rtl/rob_pkg.sv
// Shared reorder-buffer entry type and default sizing constants.
package rob_pkg;
  localparam int ROB_XLEN  = 32;
  localparam int ROB_DEPTH = 8;
  localparam int ROB_NCDB  = 6;
  localparam int ROB_REG_W = 5;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [ROB_REG_W-1:0] dest;
    logic [ROB_XLEN-1:0]  data;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buff_param_if.sv
// Dispatch / CDB / commit bundle for reorder_buff_param.
// The flush wire exists only when ROB_FLUSH_EN is defined.
interface reorder_buff_param_if
  import rob_pkg::*;
#(
  parameter int XLEN  = ROB_XLEN,
  parameter int DEPTH = ROB_DEPTH,
  parameter int NCDB  = ROB_NCDB,
  parameter int REG_W = ROB_REG_W
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   alloc_valid;
  logic [REG_W-1:0]       alloc_dest;
  logic                   alloc_ready;
  logic [TAG_W-1:0]       alloc_tag;
  logic [NCDB-1:0]        cdb_valid;
  logic [NCDB*TAG_W-1:0]  cdb_tag;
  logic [NCDB*XLEN-1:0]   cdb_data;
  logic                   commit_valid;
  logic                   commit_ready;
  logic [REG_W-1:0]       commit_dest;
  logic [XLEN-1:0]        commit_data;
  logic [TAG_W-1:0]       commit_tag;
  logic [CNT_W-1:0]       count;
  logic                   empty;
  logic                   full;
`ifdef ROB_FLUSH_EN
  logic                   flush;
`endif

  modport master (
`ifdef ROB_FLUSH_EN
    output flush,
`endif
    output alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data, commit_ready,
    input  alloc_ready, alloc_tag, commit_valid, commit_dest, commit_data, commit_tag,
    input  count, empty, full
  );

  modport slave (
`ifdef ROB_FLUSH_EN
    input  flush,
`endif
    input  alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data, commit_ready,
    output alloc_ready, alloc_tag, commit_valid, commit_dest, commit_data, commit_tag,
    output count, empty, full
  );
endinterface

// File: rtl/rob_cdb_match.sv
// Per-entry CDB tag compare; lowest lane index wins when several lanes hit.
module rob_cdb_match #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 3,
  parameter int NCDB  = 6,
  parameter int IDX   = 0
) (
  input  logic [NCDB-1:0]       i_valid,
  input  logic [NCDB*TAG_W-1:0] i_tag,
  input  logic [NCDB*XLEN-1:0]  i_data,
  output logic                  o_hit,
  output logic [XLEN-1:0]       o_data
);
  // Scan high to low so the lowest matching lane is the last writer.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int i = NCDB - 1; i >= 0; i--) begin
      if (i_valid[i] && (i_tag[i*TAG_W +: TAG_W] == TAG_W'(IDX))) begin
        o_hit  = 1'b1;
        o_data = i_data[i*XLEN +: XLEN];
      end
    end
  end
endmodule

// File: rtl/reorder_buff_param.sv
// Parameterized reorder buffer: allocates in order, completes from the CDB
// out of order, commits in order. Flush support compiled in with ROB_FLUSH_EN.
module reorder_buff_param
  import rob_pkg::*;
#(
  parameter int XLEN  = ROB_XLEN,
  parameter int DEPTH = ROB_DEPTH,
  parameter int NCDB  = ROB_NCDB,
  parameter int REG_W = ROB_REG_W
) (
  input logic                 clk,
  input logic                 rst_n,
  reorder_buff_param_if.slave bus
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic [REG_W-1:0] dest;
    logic [XLEN-1:0]  data;
  } entry_t;

  entry_t [DEPTH-1:0]          r_ent;
  logic [TAG_W-1:0]            r_head, r_tail;
  logic [CNT_W-1:0]            r_count;
  logic [DEPTH-1:0]            w_hit;
  logic [DEPTH-1:0][XLEN-1:0]  w_hdata;
  logic                        w_flush, w_full, w_alloc, w_commit;

`ifdef ROB_FLUSH_EN
  assign w_flush = bus.flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_alloc  = bus.alloc_valid && bus.alloc_ready;
  assign w_commit = bus.commit_valid && bus.commit_ready;

  // No full bypass: a same-cycle commit does not open a slot for dispatch.
  assign bus.alloc_ready  = !w_full && !w_flush;
  assign bus.alloc_tag    = r_tail;
  assign bus.commit_valid = r_ent[r_head].busy && r_ent[r_head].done && !w_flush;
  assign bus.commit_dest  = r_ent[r_head].dest;
  assign bus.commit_data  = r_ent[r_head].data;
  assign bus.commit_tag   = r_head;
  assign bus.count        = r_count;
  assign bus.empty        = (r_count == '0);
  assign bus.full         = w_full;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rob_cdb_match #(.XLEN(XLEN), .TAG_W(TAG_W), .NCDB(NCDB), .IDX(g)) u_match (
      .i_valid (bus.cdb_valid),
      .i_tag   (bus.cdb_tag),
      .i_data  (bus.cdb_data),
      .o_hit   (w_hit[g]),
      .o_data  (w_hdata[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_ent   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Only busy, not-yet-done entries accept a result; stale tags fall through.
      for (int e = 0; e < DEPTH; e++) begin
        if (w_hit[e] && r_ent[e].busy && !r_ent[e].done) begin
          r_ent[e].done <= 1'b1;
          r_ent[e].data <= w_hdata[e];
        end
      end
      if (w_commit) begin
        r_ent[r_head] <= '0;
        r_head        <= r_head + TAG_W'(1);
      end
      if (w_alloc) begin
        r_ent[r_tail] <= '{busy: 1'b1, done: 1'b0, dest: bus.alloc_dest, data: '0};
        r_tail        <= r_tail + TAG_W'(1);
      end
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
